// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data RAM port between a CPU load/store
// path and a display fetch path. Video normally wins, but a CPU that has lost
// STARVE consecutive arbitration cycles is forced to win the next one. CPU loads
// stall the processor for two cycles (address, data capture) and release it in
// the third cycle. Video is granted whenever the port is otherwise free.
module dmem_arbiter #(
    parameter int AW     = 14,
    parameter int DW     = 32,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_enable,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Starvation counter sized to hold the value STARVE itself.
    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_CPU_DATA    = 2'd1,
        ST_CPU_RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_starve_cnt;
    logic [DW-1:0]   r_cpu_rdata;
    logic            r_vid_valid;
    logic [DW-1:0]   r_vid_rdata;

    logic            w_vid_grant;
    logic            w_cpu_grant;
    logic            w_starve_ok;

    assign w_starve_ok = (r_starve_cnt < STARVE_MAX);

    // Same-cycle arbitration of the RAM port between video and CPU.
    always_comb begin
        w_vid_grant = 1'b0;
        w_cpu_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_vid_grant = vid_req && (!cpu_req || w_starve_ok);
                w_cpu_grant = cpu_req && !w_vid_grant;
            end
            // The port is idle while a load completes, so video may use it.
            ST_CPU_DATA, ST_CPU_RELEASE: begin
                w_vid_grant = vid_req;
                w_cpu_grant = 1'b0;
            end
            default: begin
                w_vid_grant = 1'b0;
                w_cpu_grant = 1'b0;
            end
        endcase
    end

    // RAM port steering: the granted requester drives the address, CPU by default.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wr    = 1'b0;
        mem_wdata = cpu_wdata;
        vid_ack   = w_vid_grant;
        if (w_vid_grant) begin
            mem_addr = vid_addr;
        end else begin
            mem_addr = cpu_addr;
        end
        if (w_cpu_grant && cpu_wr) begin
            mem_wr = 1'b1;
        end else begin
            mem_wr = 1'b0;
        end
    end

    // Processor enable: stall while a CPU access is outstanding or has lost arbitration.
    always_comb begin
        cpu_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    // Stores complete in the grant cycle; loads stall.
                    cpu_enable = w_cpu_grant && cpu_wr;
                end else begin
                    cpu_enable = 1'b1;
                end
            end
            ST_CPU_DATA:    cpu_enable = 1'b0;
            ST_CPU_RELEASE: cpu_enable = 1'b1;
            default:        cpu_enable = 1'b0;
        endcase
    end

    // Load sequencing FSM and starvation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cpu_grant) begin
                        r_starve_cnt <= '0;
                        if (cpu_wr) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_CPU_DATA;
                        end
                    end else if (cpu_req && w_vid_grant) begin
                        r_state <= ST_IDLE;
                        if (r_starve_cnt < STARVE_MAX) begin
                            r_starve_cnt <= r_starve_cnt + STARVE_ONE;
                        end else begin
                            r_starve_cnt <= r_starve_cnt;
                        end
                    end else begin
                        r_state      <= ST_IDLE;
                        r_starve_cnt <= r_starve_cnt;
                    end
                end
                ST_CPU_DATA: begin
                    r_state <= ST_CPU_RELEASE;
                end
                // The held cpu_req belongs to the load just served; do not re-grant it.
                ST_CPU_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_starve_cnt <= '0;
                end
            endcase
        end
    end

    // CPU load data register: captures the RAM output only in the data cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
        end else if (r_state == ST_CPU_DATA) begin
            r_cpu_rdata <= mem_rdata;
        end else begin
            r_cpu_rdata <= r_cpu_rdata;
        end
    end

    // Video return pipeline: valid follows a grant by one cycle; last word is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vid_valid <= 1'b0;
            r_vid_rdata <= '0;
        end else begin
            r_vid_valid <= w_vid_grant;
            if (r_vid_valid) begin
                r_vid_rdata <= mem_rdata;
            end else begin
                r_vid_rdata <= r_vid_rdata;
            end
        end
    end

    // Video data shows the RAM word in its valid cycle and holds it afterwards.
    always_comb begin
        if (r_vid_valid) begin
            vid_rdata = mem_rdata;
        end else begin
            vid_rdata = r_vid_rdata;
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign vid_valid = r_vid_valid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for dmem_arbiter with a synchronous-read RAM model.
module tb_dmem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_enable;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          vid_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_enable (cpu_enable),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .vid_valid  (vid_valid),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial RAM contents.
    function automatic logic [31:0] init_word(input logic [13:0] a);
        case (a)
            14'h010: return 32'hDEADBEEF;
            14'h030: return 32'hA5A50030;
            14'h040: return 32'hC0DE0040;
            14'h050: return 32'h0BADF00D;
            default: return 32'h5A5A0000 | {18'd0, a};
        endcase
    endfunction

    // Synchronous-read single-port RAM model, preloaded on the first clock edge.
    logic [31:0] ram [0:1023];
    logic        ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(14'(i));
            ram_ready <= 1'b1;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_wr) ram[mem_addr[9:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_cpu_rdata", 64'(cpu_rdata), 64'h0);
        check_eq("rst_vid_valid", 64'(vid_valid), 64'h0);
        check_eq("rst_cpu_enable", 64'(cpu_enable), 64'h1);
        check_eq("rst_vid_ack", 64'(vid_ack), 64'h0);
        check_eq("rst_mem_wr", 64'(mem_wr), 64'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // S1: CPU load at 0x010
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h010;
        @(negedge clk);
        check_eq("s1_en_c1", 64'(cpu_enable), 64'h0);
        check_eq("s1_addr", 64'(mem_addr), 64'h010);
        check_eq("s1_wr", 64'(mem_wr), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("s1_en_c2", 64'(cpu_enable), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("s1_en_c3", 64'(cpu_enable), 64'h1);
        check_eq("s1_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        check_eq("s1_no_regrant_wr", 64'(mem_wr), 64'h0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("s1_idle_en", 64'(cpu_enable), 64'h1);
        check_eq("s1_rdata_hold", 64'(cpu_rdata), 64'hDEADBEEF);
        next_cycle();

        // S2: CPU store then load back
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h020; cpu_wdata = 32'h12345678;
        @(negedge clk);
        check_eq("s2_mem_wr", 64'(mem_wr), 64'h1);
        check_eq("s2_en", 64'(cpu_enable), 64'h1);
        check_eq("s2_addr", 64'(mem_addr), 64'h020);
        check_eq("s2_wdata", 64'(mem_wdata), 64'h12345678);
        next_cycle();
        cpu_wr = 1'b0; cpu_wdata = 32'h0;
        @(negedge clk);
        check_eq("s2_ld_en1", 64'(cpu_enable), 64'h0);
        check_eq("s2_ld_wr", 64'(mem_wr), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("s2_ld_en2", 64'(cpu_enable), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("s2_ld_en3", 64'(cpu_enable), 64'h1);
        check_eq("s2_ld_rdata", 64'(cpu_rdata), 64'h12345678);
        next_cycle();
        cpu_req = 1'b0;

        // S3: video continuous with CPU load pending; starvation forces the CPU in
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h050; vid_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vid_addr = 14'(14'h100 + i);
            @(negedge clk);
            check_eq("s3_vid_ack", 64'(vid_ack), 64'h1);
            check_eq("s3_cpu_stall", 64'(cpu_enable), 64'h0);
            check_eq("s3_vid_addr", 64'(mem_addr), 64'(14'h100 + i));
            check_eq("s3_no_wr", 64'(mem_wr), 64'h0);
            if (i > 0) begin
                check_eq("s3_vvalid", 64'(vid_valid), 64'h1);
                check_eq("s3_vrdata", 64'(vid_rdata), 64'(init_word(14'(14'h100 + i - 1))));
            end
            next_cycle();
        end
        vid_addr = 14'h104;
        @(negedge clk);
        check_eq("s3_forced_ack", 64'(vid_ack), 64'h0);
        check_eq("s3_forced_en", 64'(cpu_enable), 64'h0);
        check_eq("s3_forced_addr", 64'(mem_addr), 64'h050);
        check_eq("s3_last_vrdata", 64'(vid_rdata), 64'(init_word(14'h103)));
        next_cycle();
        vid_addr = 14'h105;
        @(negedge clk);
        check_eq("s3_data_vack", 64'(vid_ack), 64'h1);
        check_eq("s3_data_en", 64'(cpu_enable), 64'h0);
        check_eq("s3_data_vvalid", 64'(vid_valid), 64'h0);
        next_cycle();
        vid_addr = 14'h106;
        @(negedge clk);
        check_eq("s3_rel_vack", 64'(vid_ack), 64'h1);
        check_eq("s3_rel_en", 64'(cpu_enable), 64'h1);
        check_eq("s3_rel_rdata", 64'(cpu_rdata), 64'h0BADF00D);
        check_eq("s3_rel_vrdata", 64'(vid_rdata), 64'(init_word(14'h105)));
        next_cycle();
        vid_req = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check_eq("s3_tail_vvalid", 64'(vid_valid), 64'h1);
        check_eq("s3_tail_vrdata", 64'(vid_rdata), 64'(init_word(14'h106)));
        next_cycle();
        // Counter must have cleared: video wins again against a pending CPU
        vid_req = 1'b1; vid_addr = 14'h107; cpu_req = 1'b1; cpu_addr = 14'h010;
        @(negedge clk);
        check_eq("s3_cnt_clr_vack", 64'(vid_ack), 64'h1);
        check_eq("s3_cnt_clr_en", 64'(cpu_enable), 64'h0);
        next_cycle();
        vid_req = 1'b0;
        @(negedge clk);
        check_eq("s3_cpu_addr", 64'(mem_addr), 64'h010);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("s3_ld2_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        next_cycle();
        cpu_req = 1'b0;

        // S4: video arrives during CPU_DATA
        cpu_req = 1'b1; cpu_addr = 14'h030;
        @(negedge clk);
        check_eq("s4_grant_en", 64'(cpu_enable), 64'h0);
        next_cycle();
        vid_req = 1'b1; vid_addr = 14'h040;
        @(negedge clk);
        check_eq("s4_data_vack", 64'(vid_ack), 64'h1);
        check_eq("s4_data_addr", 64'(mem_addr), 64'h040);
        next_cycle();
        vid_req = 1'b0;
        @(negedge clk);
        check_eq("s4_vvalid", 64'(vid_valid), 64'h1);
        check_eq("s4_vrdata", 64'(vid_rdata), 64'hC0DE0040);
        check_eq("s4_cpu_rdata", 64'(cpu_rdata), 64'hA5A50030);
        check_eq("s4_rel_en", 64'(cpu_enable), 64'h1);
        next_cycle();

        // S5: reset pulsed in CPU_DATA abandons the load
        cpu_addr = 14'h010;
        @(negedge clk);
        check_eq("s5_grant_en", 64'(cpu_enable), 64'h0);
        next_cycle();
        vid_req = 1'b1; vid_addr = 14'h040;
        @(negedge clk);
        check_eq("s5_data_vack", 64'(vid_ack), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("s5_async_rdata", 64'(cpu_rdata), 64'h0);
        check_eq("s5_async_vvalid", 64'(vid_valid), 64'h0);
        next_cycle();
        vid_req = 1'b0;
        @(negedge clk);
        check_eq("s5_hold_vvalid", 64'(vid_valid), 64'h0);
        check_eq("s5_hold_rdata", 64'(cpu_rdata), 64'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("s5_re_en1", 64'(cpu_enable), 64'h0);
        check_eq("s5_re_addr", 64'(mem_addr), 64'h010);
        next_cycle();
        @(negedge clk);
        check_eq("s5_re_en2", 64'(cpu_enable), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("s5_re_en3", 64'(cpu_enable), 64'h1);
        check_eq("s5_re_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        next_cycle();
        cpu_req = 1'b0;

        // S6: video only, 8 back-to-back grants
        vid_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vid_addr = 14'(14'h180 + i);
            @(negedge clk);
            check_eq("s6_vack", 64'(vid_ack), 64'h1);
            check_eq("s6_en", 64'(cpu_enable), 64'h1);
            check_eq("s6_addr", 64'(mem_addr), 64'(14'h180 + i));
            check_eq("s6_vvalid", 64'(vid_valid), (i > 0) ? 64'h1 : 64'h0);
            if (i > 0) check_eq("s6_vrdata", 64'(vid_rdata), 64'(init_word(14'(14'h180 + i - 1))));
            next_cycle();
        end
        vid_req = 1'b0;
        @(negedge clk);
        check_eq("s6_end_vack", 64'(vid_ack), 64'h0);
        check_eq("s6_end_vvalid", 64'(vid_valid), 64'h1);
        check_eq("s6_end_vrdata", 64'(vid_rdata), 64'(init_word(14'h187)));
        next_cycle();
        @(negedge clk);
        check_eq("s6_drain_vvalid", 64'(vid_valid), 64'h0);
        check_eq("s6_drain_vrdata_hold", 64'(vid_rdata), 64'(init_word(14'h187)));
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
